// File: rtl/div_pkg.sv
// Shared types and constants for the iterative MIPS divider.
//   div_state_e : IDLE / DIV / DONE sequencing states
//   DIV_WIDTH   : operand and result width (32)
//   DIV_CNT_W   : iteration counter width (5)
//   DIV0_QUOT   : quotient reported for a zero divisor
//   OVF_QUOT    : quotient reported for 0x80000000 / -1
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] OVF_QUOT  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage <-> divider handshake bundle.
//   master : execute stage (drives start/operands/annul/result_ack)
//   slave  : divider (drives busy/result_valid/hi/lo)
interface div_unit_if;
  import div_pkg::*;

  logic                 start;
  logic                 signed_div;
  logic                 annul;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 result_ack;
  logic                 busy;
  logic                 result_valid;
  logic [DIV_WIDTH-1:0] hi;
  logic [DIV_WIDTH-1:0] lo;

  modport master (
    output start, signed_div, annul, dividend, divisor, result_ack,
    input  busy, result_valid, hi, lo
  );

  modport slave (
    input  start, signed_div, annul, dividend, divisor, result_ack,
    output busy, result_valid, hi, lo
  );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 iteration on the {rem, quot} shift pair.
//   rem/quot         : current partial remainder (33b) and quotient/dividend register
//   dvs              : divisor magnitude
//   rem_next/quot_next : values after shift + trial subtract
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem,
  input  logic [DIV_WIDTH-1:0] quot,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH:0]   rem_next,
  output logic [DIV_WIDTH-1:0] quot_next
);

  logic [DIV_WIDTH+1:0] rem_sh;
  logic [DIV_WIDTH+1:0] diff;

  // Shift the next dividend bit into the remainder, then try subtracting.
  always_comb begin
    rem_sh    = {rem, quot[DIV_WIDTH-1]};
    diff      = rem_sh - {2'b00, dvs};
    rem_next  = rem_sh[DIV_WIDTH:0];
    quot_next = {quot[DIV_WIDTH-2:0], 1'b0};
    if (!diff[DIV_WIDTH+1]) begin
      rem_next  = diff[DIV_WIDTH:0];
      quot_next = {quot[DIV_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit MIPS DIV/DIVU unit producing HI (remainder) / LO (quotient).
// Optional macro DIV_BYPASS_EN: a zero divisor at launch skips the iterations
// and goes straight to DONE with the divide-by-zero values.
//   clk, rst : clock, synchronous active-high reset
//   bus      : div_unit_if.slave (start/signed_div/annul/dividend/divisor/
//              result_ack in; busy/result_valid/hi/lo out)
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH-1:0]     dvs_q;
  logic [WIDTH-1:0]     dend_raw_q;
  logic                 neg_quot_q;
  logic                 neg_rem_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH:0]       rem_nx_c;
  logic [WIDTH-1:0]     quot_nx_c;
  logic [WIDTH-1:0]     dend_mag_c;
  logic [WIDTH-1:0]     dvs_mag_c;
  logic [WIDTH-1:0]     quot_fin_c;
  logic [WIDTH-1:0]     rem_fin_c;
  logic                 zero_bypass_c;

  div_step u_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .dvs       (dvs_q),
    .rem_next  (rem_nx_c),
    .quot_next (quot_nx_c)
  );

  // Operand magnitudes at launch; DIVU uses the raw bit patterns.
  always_comb begin
    dend_mag_c = bus.dividend;
    dvs_mag_c  = bus.divisor;
    if (bus.signed_div && bus.dividend[WIDTH-1]) dend_mag_c = WIDTH'(-bus.dividend);
    if (bus.signed_div && bus.divisor[WIDTH-1])  dvs_mag_c  = WIDTH'(-bus.divisor);
  end

  // Sign correction of the final iteration's result.
  // 0x80000000 / -1 falls out naturally: -(0x80000000) wraps to itself.
  always_comb begin
    quot_fin_c = neg_quot_q ? WIDTH'(-quot_nx_c) : quot_nx_c;
    rem_fin_c  = neg_rem_q  ? WIDTH'(-rem_nx_c[WIDTH-1:0]) : rem_nx_c[WIDTH-1:0];
  end

`ifdef DIV_BYPASS_EN
  assign zero_bypass_c = (bus.divisor == '0);
`else
  assign zero_bypass_c = 1'b0;
`endif

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      dend_raw_q <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (bus.annul) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            neg_quot_q <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_rem_q  <= bus.signed_div & bus.dividend[WIDTH-1];
            quot_q     <= dend_mag_c;
            dvs_q      <= dvs_mag_c;
            dend_raw_q <= bus.dividend;
            rem_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (zero_bypass_c) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              hi_q    <= bus.dividend;
              lo_q    <= DIV0_QUOT;
            end else begin
              state_q <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          rem_q  <= rem_nx_c;
          quot_q <= quot_nx_c;
          cnt_q  <= DIV_CNT_W'(cnt_q + 1'b1);
          if (cnt_q == DIV_CNT_W'(WIDTH - 1)) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            if (dvs_q == '0) begin
              hi_q <= dend_raw_q;
              lo_q <= DIV0_QUOT;
            end else begin
              hi_q <= rem_fin_c;
              lo_q <= quot_fin_c;
            end
          end
        end
        ST_DONE: begin
          if (bus.result_ack) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// DIV/DIVU operations checked against a 64-bit arithmetic reference model.
module tb_div_unit;
  import div_pkg::*;

`ifdef DIV_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from plain wide arithmetic.
  function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                        input int ack_dly, input bit glitch);
    logic [63:0] e;
    int lat;
    bit seen;
    int exp_lat;
    e = ref_div(sd, a, b);
    exp_lat = (BYPASS && b == 32'd0) ? 0 : 32;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = sd; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.signed_div = 1'($urandom); bus.dividend = $urandom; bus.divisor = $urandom;
    check("busy_rise", bus.busy, 1);
    lat = 0;
    seen = bus.result_valid;
    while (!seen && lat < 100) begin
      bus.start = (glitch && lat == 4);
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.result_valid;
    end
    bus.start = 1'b0;
    if (!seen) begin
      check("valid_timeout", 0, 1);
      return;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("lo", bus.lo, e[31:0]);
    check("hi", bus.hi, e[63:32]);
    check("busy_done", bus.busy, 1);
    for (int k = 0; k < ack_dly; k++) begin
      if (k == 1) bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("hold_valid", bus.result_valid, 1);
      check("hold_lo", bus.lo, e[31:0]);
      check("hold_hi", bus.hi, e[63:32]);
    end
    bus.result_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.result_ack = 1'b0;
    check("busy_fall", bus.busy, 0);
    check("valid_fall", bus.result_valid, 0);
    check("lo_after_ack", bus.lo, e[31:0]);
    check("hi_after_ack", bus.hi, e[63:32]);
    prev_hi = e[63:32];
    prev_lo = e[31:0];
  endtask

  task automatic do_annul(input bit sd, input logic [31:0] a, input logic [31:0] b, input int iters);
    bit any_valid;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = sd; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (iters) @(posedge clk);
    @(negedge clk);
    bus.annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul = 1'b0;
    check("annul_busy", bus.busy, 0);
    check("annul_valid", bus.result_valid, 0);
    check("annul_hi", bus.hi, prev_hi);
    check("annul_lo", bus.lo, prev_lo);
    any_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_valid |= bus.result_valid;
    end
    check("annul_no_valid", 32'(any_valid), 0);
    check("annul_hi_late", bus.hi, prev_hi);
    check("annul_lo_late", bus.lo, prev_lo);
  endtask

  initial begin
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.result_ack = 1'b0;
    prev_hi = '0; prev_lo = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, 0, 1'b0);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    check("ovf_lo", bus.lo, OVF_QUOT);
    do_div(1'b1, 32'h1234_5678, 32'd0, 0, 1'b0);
    do_div(1'b0, 32'h1234_5678, 32'd0, 2, 1'b0);
    do_div(1'b0, 32'hDEAD_BEEF, 32'd13, 5, 1'b1);

    do_annul(1'b0, 32'd5000, 32'd3, 10);

    // annul and start in the same IDLE cycle: annul wins
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.annul = 1'b0;
    check("annul_beats_start", bus.busy, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      do_div(1'($urandom), a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // reset while holding a result in DONE
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int w;
      w = 0;
      while (!bus.result_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("rst_test_valid", bus.result_valid, 1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.result_valid, 0);
    check("mid_rst_hi", bus.hi, 0);
    check("mid_rst_lo", bus.lo, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit MIPS divider that produces the HI/LO pair written back to the HI/LO register file. It is launched by the execute stage for DIV/DIVU and runs a restoring radix-2 algorithm on posedge `clk`. It presents remainder on `hi` and quotient on `lo`, holding them with `result_valid` until the pipeline accepts them. `busy` stalls upstream stages while a division is in flight.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk` in 1: clock, posedge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: launch request, sampled only in IDLE.
- `signed_div` in 1: 1 = DIV (signed), 0 = DIVU; captured with `start`.
- `annul` in 1: abort the current operation (flush or exception).
- `dividend` in 32: rs operand, captured with `start`.
- `divisor` in 32: rt operand, captured with `start`.
- `result_ack` in 1: consumer wrote HI/LO this cycle.
- `busy` out 1: high in DIV and DONE states.
- `result_valid` out 1: high in DONE only.
- `hi` out 32: remainder.
- `lo` out 32: quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - DIV: 32 iterations, counter 0..31.
  - DONE: holds the result until acknowledged.
- Launch (IDLE & `start` & !`annul`):
  - Latch `signed_div` and the operand signs.
  - Latch |dividend| and |divisor|; magnitudes are taken only when `signed_div`=1.
  - Clear the 33-bit partial remainder; counter = 0; go to DIV.
- DIV step:
  - Shift {rem, quot} left by 1.
  - Trial subtract divisor magnitude from rem.
  - If non-negative, keep the difference and set quotient bit = 1.
  - Counter increments each step; on step 31 go to DONE.
- Result correction is applied at the DIV→DONE edge:
  - Quotient is negated if signed and operand signs differ.
  - Remainder is negated if signed and dividend negative.
  - Net effect: quotient truncates toward zero; remainder takes the dividend's sign.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Divisor zero, both modes: lo = 0xFFFFFFFF, hi = raw dividend. The override is applied at the DONE load.
- DONE: `hi`/`lo` are stable; `result_ack` → IDLE. `hi`/`lo` then hold their values until the next DONE load.
- `annul`, any state: → IDLE next edge; `result_valid` drops; `hi`/`lo` hold. `annul` beats `start` and `result_ack` in the same cycle.
- `start` outside IDLE is ignored. There is no queueing.

## Timing
- Reset values:
  - State IDLE; `busy` = 0; `result_valid` = 0.
  - `hi` = 0; `lo` = 0; counter = 0.
- `rst` mid-operation: every output returns to its reset value on that edge.
- Latency: the edge sampling `start` is edge 0. Iterations occur on edges 1..32. `result_valid` is high from edge 32 onward: 32 cycles of `busy` before valid.
- `busy` rises on edge 0 and falls on the edge that samples `result_ack` or `annul`.
- Back-to-back divides need at least one IDLE cycle between the ack and the next `start`.
- `hi`/`lo` change only at the DONE load edge, at reset, or at the DIV_BYPASS_EN fast-path load.

## Configuration
- `DIV_BYPASS_EN` defined: a divisor of zero at launch goes IDLE → DONE on edge 0 with the divide-by-zero values. `result_valid` is high after 1 edge.
- `DIV_BYPASS_EN` undefined: a zero divisor runs the full 32 iterations. The same override values are still loaded at DONE.
- All other behaviour is identical in both builds.

## Structure
- `div_pkg` holds:
  - the state enum (IDLE/DIV/DONE);
  - `DIV_WIDTH` = 32 and `DIV_CNT_W` = 5;
  - the constants `DIV0_QUOT` = 32'hFFFF_FFFF and `OVF_QUOT` = 32'h8000_0000.
- Sub-module `div_step` (combinational):
  - Inputs: {rem, quot}, divisor magnitude.
  - Outputs: next {rem, quot}.
  - Instantiated once in `div_unit`.

## Test plan
- DIVU 100 / 7, ack on the first valid cycle → `result_valid` high exactly 32 edges after `start`; `lo` = 14, `hi` = 2; `busy` falls after ack.
- DIV 0xFFFFFFF9 (−7) / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIV 0x12345678 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x12345678. Valid arrives after 1 edge with `DIV_BYPASS_EN`, 32 edges without.
- `annul` at iteration 10 → IDLE next edge; `result_valid` never rises; `hi`/`lo` keep the prior result. `start` during DIV is ignored.
- `result_ack` withheld 5 cycles → `hi`/`lo`/`result_valid` stable throughout. `rst` asserted in DONE → all outputs 0 next edge.
